// File: rtl/ysyx_22041071_if_axi_master.sv
// Instruction-fetch AXI read master: one outstanding single-beat fetch per request.
// Optional macro YSYX_22041071_IF_ALIGN_CHECK_EN rejects PCs with pc[1:0]!=0 locally, without an AXI access.
module ysyx_22041071_if_axi_master #(
  parameter logic [2:0] AXI_SIZE  = 3'b011,
  parameter logic [1:0] AXI_BURST = 2'b01
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req_valid,
  input  logic [63:0] req_pc,
  output logic        req_ready,
  input  logic        flush,

  output logic        axi_ar_valid,
  input  logic        axi_ar_ready,
  output logic [63:0] axi_ar_addr,
  output logic [7:0]  axi_ar_len,
  output logic [2:0]  axi_ar_size,
  output logic [1:0]  axi_ar_burst,

  input  logic        axi_r_valid,
  output logic        axi_r_ready,
  input  logic [63:0] axi_r_data,
  input  logic [1:0]  axi_r_resp,

  output logic        cpu_r_valid,
  output logic [63:0] cpu_r_data,
  output logic [63:0] cpu_r_addr,
  output logic [1:0]  cpu_resp,
  input  logic        ready2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] data_q, data_d;
  logic [1:0]  resp_q, resp_d;

  logic        req_fire;
  logic        misaligned;

  assign req_fire = req_valid && (state_q == IDLE);

`ifdef YSYX_22041071_IF_ALIGN_CHECK_EN
  assign misaligned = (req_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      pc_q    <= 64'd0;
      data_q  <= 64'd0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  // A flushed fetch must still finish its AXI handshakes, so drop only suppresses forwarding.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    data_d  = data_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (req_fire) begin
          pc_d = req_pc;
          if (misaligned) begin
            data_d  = 64'd0;
            resp_d  = 2'b10;
            state_d = RSP;
          end else begin
            state_d = AR;
          end
        end
      end
      AR: begin
        if (flush) drop_d = 1'b1;
        if (axi_ar_ready) state_d = R;
      end
      R: begin
        if (flush) drop_d = 1'b1;
        if (axi_r_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            data_d  = axi_r_data;
            resp_d  = axi_r_resp;
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (flush || ready2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    axi_ar_valid = (state_q == AR);
    axi_r_ready  = (state_q == R);
    cpu_r_valid  = (state_q == RSP);
  end

  assign axi_ar_addr  = {pc_q[63:3], 3'b000};
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = AXI_SIZE;
  assign axi_ar_burst = AXI_BURST;

  assign cpu_r_data = data_q;
  assign cpu_r_addr = pc_q;
  assign cpu_resp   = resp_q;

endmodule

// File: tb/tb_ysyx_22041071_if_axi_master.sv
// Directed bench for the IF AXI read master: latency, back-pressure, flush, reset and alignment.
module tb_ysyx_22041071_if_axi_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        req_ready;
  logic        flush;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        cpu_r_valid;
  logic [63:0] cpu_r_data;
  logic [63:0] cpu_r_addr;
  logic [1:0]  cpu_resp;
  logic        ready2;

  int vectors;
  int miscompares;

  ysyx_22041071_if_axi_master dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .req_ready    (req_ready),
    .flush        (flush),
    .axi_ar_valid (axi_ar_valid),
    .axi_ar_ready (axi_ar_ready),
    .axi_ar_addr  (axi_ar_addr),
    .axi_ar_len   (axi_ar_len),
    .axi_ar_size  (axi_ar_size),
    .axi_ar_burst (axi_ar_burst),
    .axi_r_valid  (axi_r_valid),
    .axi_r_ready  (axi_r_ready),
    .axi_r_data   (axi_r_data),
    .axi_r_resp   (axi_r_resp),
    .cpu_r_valid  (cpu_r_valid),
    .cpu_r_data   (cpu_r_data),
    .cpu_r_addr   (cpu_r_addr),
    .cpu_resp     (cpu_resp),
    .ready2       (ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] pc, input logic fl, input logic r2);
    req_valid = rv;
    req_pc    = pc;
    flush     = fl;
    ready2    = r2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    checkOutput({tag, "_ar_valid"}, 64'(axi_ar_valid), 64'd0);
    checkOutput({tag, "_r_ready"}, 64'(axi_r_ready), 64'd0);
    checkOutput({tag, "_cpu_valid"}, 64'(cpu_r_valid), 64'd0);
    checkOutput({tag, "_cpu_data"}, cpu_r_data, 64'd0);
    checkOutput({tag, "_cpu_addr"}, cpu_r_addr, 64'd0);
    checkOutput({tag, "_cpu_resp"}, 64'(cpu_resp), 64'd0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b0;
    axi_r_data   = 64'd0;
    axi_r_resp   = 2'b00;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    #12;
    checkResetOutputs("rst");
    checkOutput("ar_len", 64'(axi_ar_len), 64'd0);
    checkOutput("ar_size", 64'(axi_ar_size), 64'd3);
    checkOutput("ar_burst", 64'(axi_ar_burst), 64'd1);
    tick();
    reset = 1'b1;
    tick();

    // Zero-wait slave: cpu_r_valid appears on the third edge after acceptance.
    axi_ar_ready = 1'b1;
    axi_r_valid  = 1'b1;
    axi_r_data   = 64'h1111_2222_3333_4444;
    axi_r_resp   = 2'b00;
    applyStimulus(1'b1, 64'h8000_0004, 1'b0, 1'b0);
    checkOutput("t1_req_ready", 64'(req_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("t1_ar_valid", 64'(axi_ar_valid), 64'd1);
    checkOutput("t1_ar_addr", axi_ar_addr, 64'h8000_0000);
    checkOutput("t1_req_ready_busy", 64'(req_ready), 64'd0);
    checkOutput("t1_cpu_valid_c1", 64'(cpu_r_valid), 64'd0);
    tick();
    checkOutput("t1_r_ready", 64'(axi_r_ready), 64'd1);
    checkOutput("t1_ar_valid_off", 64'(axi_ar_valid), 64'd0);
    checkOutput("t1_cpu_valid_c2", 64'(cpu_r_valid), 64'd0);
    tick();
    checkOutput("t1_cpu_valid", 64'(cpu_r_valid), 64'd1);
    checkOutput("t1_cpu_data", cpu_r_data, 64'h1111_2222_3333_4444);
    checkOutput("t1_cpu_addr", cpu_r_addr, 64'h8000_0004);
    checkOutput("t1_cpu_resp", 64'(cpu_resp), 64'd0);
    checkOutput("t1_r_ready_off", 64'(axi_r_ready), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("t1_done_valid", 64'(cpu_r_valid), 64'd0);
    checkOutput("t1_done_ready", 64'(req_ready), 64'd1);

    // AR back-pressure for 4 cycles, SLVERR response, then IF stalls 5 cycles.
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b0;
    applyStimulus(1'b1, 64'h8000_1014, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_ar_valid_%0d", i), 64'(axi_ar_valid), 64'd1);
      checkOutput($sformatf("t2_ar_addr_%0d", i), axi_ar_addr, 64'h8000_1010);
      tick();
    end
    checkOutput("t2_ar_still", 64'(axi_ar_valid), 64'd1);
    axi_ar_ready = 1'b1;
    tick();
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b1;
    axi_r_data   = 64'hDEAD_BEEF_0BAD_F00D;
    axi_r_resp   = 2'b10;
    checkOutput("t2_r_ready", 64'(axi_r_ready), 64'd1);
    tick();
    axi_r_valid = 1'b0;
    axi_r_data  = 64'd0;
    axi_r_resp  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_hold_valid_%0d", i), 64'(cpu_r_valid), 64'd1);
      checkOutput($sformatf("t2_hold_data_%0d", i), cpu_r_data, 64'hDEAD_BEEF_0BAD_F00D);
      checkOutput($sformatf("t2_hold_resp_%0d", i), 64'(cpu_resp), 64'd2);
      checkOutput($sformatf("t2_hold_rdy_%0d", i), 64'(req_ready), 64'd0);
      tick();
    end
    checkOutput("t2_hold_addr", cpu_r_addr, 64'h8000_1014);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("t2_done_ready", 64'(req_ready), 64'd1);

    // Flush while in R: the late beat is consumed but never forwarded.
    axi_ar_ready = 1'b1;
    applyStimulus(1'b1, 64'h8000_2000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_in_r", 64'(axi_r_ready), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    checkOutput("t3_wait1_rready", 64'(axi_r_ready), 64'd1);
    checkOutput("t3_wait1_valid", 64'(cpu_r_valid), 64'd0);
    tick();
    axi_r_valid = 1'b1;
    axi_r_data  = 64'h5555_6666_7777_8888;
    checkOutput("t3_wait2_valid", 64'(cpu_r_valid), 64'd0);
    tick();
    axi_r_valid = 1'b0;
    checkOutput("t3_after_valid", 64'(cpu_r_valid), 64'd0);
    checkOutput("t3_after_ready", 64'(req_ready), 64'd1);
    checkOutput("t3_after_rready", 64'(axi_r_ready), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);

    // Flush together with a request in IDLE: the new fetch proceeds and is forwarded.
    axi_r_valid = 1'b1;
    axi_r_data  = 64'hAAAA_BBBB_CCCC_DDDD;
    axi_r_resp  = 2'b00;
    applyStimulus(1'b1, 64'h8000_3008, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("t4_ar_valid", 64'(axi_ar_valid), 64'd1);
    checkOutput("t4_ar_addr", axi_ar_addr, 64'h8000_3008);
    tick();
    tick();
    checkOutput("t4_cpu_valid", 64'(cpu_r_valid), 64'd1);
    checkOutput("t4_cpu_data", cpu_r_data, 64'hAAAA_BBBB_CCCC_DDDD);

    // Flush in RSP kills the beat next cycle even with ready2 low.
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("t5_valid_off", 64'(cpu_r_valid), 64'd0);
    checkOutput("t5_req_ready", 64'(req_ready), 64'd1);
    axi_r_valid = 1'b0;

    // Reset asserted mid-AR: outputs return to reset values before the next edge.
    axi_ar_ready = 1'b0;
    applyStimulus(1'b1, 64'h8000_4000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    checkOutput("t6_in_ar", 64'(axi_ar_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("t6_async");
    axi_ar_ready = 1'b1;
    axi_r_valid  = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t6_no_beat_%0d", i), 64'(cpu_r_valid), 64'd0);
    end
    axi_r_valid = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    tick();

    // Misaligned PC handling depends on the build option.
    axi_ar_ready = 1'b1;
    axi_r_valid  = 1'b1;
    axi_r_data   = 64'h0123_4567_89AB_CDEF;
    axi_r_resp   = 2'b00;
    applyStimulus(1'b1, 64'h8000_0002, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
`ifdef YSYX_22041071_IF_ALIGN_CHECK_EN
    checkOutput("t7_no_ar", 64'(axi_ar_valid), 64'd0);
    checkOutput("t7_cpu_valid", 64'(cpu_r_valid), 64'd1);
    checkOutput("t7_cpu_resp", 64'(cpu_resp), 64'd2);
    checkOutput("t7_cpu_data", cpu_r_data, 64'd0);
    checkOutput("t7_cpu_addr", cpu_r_addr, 64'h8000_0002);
`else
    checkOutput("t7_ar_valid", 64'(axi_ar_valid), 64'd1);
    checkOutput("t7_ar_addr", axi_ar_addr, 64'h8000_0000);
    tick();
    tick();
    checkOutput("t7_cpu_valid", 64'(cpu_r_valid), 64'd1);
    checkOutput("t7_cpu_resp", 64'(cpu_resp), 64'd0);
    checkOutput("t7_cpu_data", cpu_r_data, 64'h0123_4567_89AB_CDEF);
    checkOutput("t7_cpu_addr", cpu_r_addr, 64'h8000_0002);
`endif
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    checkOutput("t7_done_ready", 64'(req_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_if_axi_master.md
YSYX_22041071_IF_AXI_MASTER -- requirements
Module: ysyx_22041071_if_axi_master

Interface
REQ-001 SHALL have parameter AXI_SIZE, default 3'b011, driven on axi_ar_size (8-byte beat).
REQ-002 SHALL have parameter AXI_BURST, default 2'b01, driven on axi_ar_burst (INCR).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, fetch request from PC generation.
REQ-006 SHALL have port req_pc, input, 64, fetch PC.
REQ-007 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-008 SHALL have port flush, input, 1, redirect; discards any in-flight fetch.
REQ-009 SHALL have port axi_ar_valid, output, 1, AXI read-address valid.
REQ-010 SHALL have port axi_ar_ready, input, 1, AXI read-address ready.
REQ-011 SHALL have port axi_ar_addr, output, 64, 8-byte-aligned fetch address.
REQ-012 SHALL have port axi_ar_len, output, 8, constant 0 (single beat).
REQ-013 SHALL have ports axi_ar_size (output, 3) and axi_ar_burst (output, 2), driven from the parameters.
REQ-014 SHALL have port axi_r_valid, input, 1, AXI read-data valid.
REQ-015 SHALL have port axi_r_ready, output, 1, AXI read-data ready.
REQ-016 SHALL have port axi_r_data, input, 64, read beat.
REQ-017 SHALL have port axi_r_resp, input, 2, read response.
REQ-018 SHALL have port cpu_r_valid, output, 1, fetched beat valid toward the IF stage.
REQ-019 SHALL have port cpu_r_data, output, 64, fetched beat.
REQ-020 SHALL have port cpu_r_addr, output, 64, original unaligned PC of the beat (IF selects the word with bit 2).
REQ-021 SHALL have port cpu_resp, output, 2, response code of the beat.
REQ-022 SHALL have port ready2, input, 1, IF stage accepts the beat when high with cpu_r_valid.

Function
REQ-023 SHALL implement FSM IDLE, AR, R, RSP; exactly one outstanding fetch.
REQ-024 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, capture req_pc and enter AR on the next edge.
REQ-025 SHALL assert axi_ar_valid only in AR with axi_ar_addr={pc[63:3],3'b000} held stable; enter R on axi_ar_ready.
REQ-026 SHALL assert axi_r_ready only in R; on axi_r_valid capture data/resp and enter RSP.
REQ-027 SHALL assert cpu_r_valid only in RSP, holding data/addr/resp stable until ready2; return to IDLE on cpu_r_valid&&ready2.
REQ-028 SHALL give minimum latency of 3 cycles from request acceptance to cpu_r_valid, with zero-wait slave.
REQ-029 SHALL set drop flag on flush in AR or R: AR stays asserted until handshake (AXI rule); response consumed, not forwarded; go to IDLE.
REQ-030 SHALL, on flush in RSP, deassert cpu_r_valid next cycle and go IDLE, even if ready2 is high the same cycle.
REQ-031 SHALL, on flush and req_valid both in IDLE, accept the request (flush kills older fetches only).
REQ-032 SHALL forward a nonzero axi_r_resp unchanged on cpu_resp.

Reset
REQ-033 SHALL on reset low: state IDLE, drop flag 0, req_ready 1, axi_ar_valid 0, axi_r_ready 0, cpu_r_valid 0, data/addr/resp registers 0.
REQ-034 SHALL, if reset asserts mid-transaction, abandon it; no beat is ever forwarded afterward.

Configuration
REQ-035 SHALL, with YSYX_22041071_IF_ALIGN_CHECK_EN defined, skip AXI for req_pc[1:0]!=0 and go IDLE->RSP with cpu_resp=2'b10, cpu_r_data=0.
REQ-036 SHALL, without YSYX_22041071_IF_ALIGN_CHECK_EN, issue every request to AXI regardless of alignment.

Verification
REQ-037 SHALL cover: req_pc=0x80000004, zero-wait slave data 0x1111_2222_3333_4444 -> ar_addr 0x80000000, cpu_r_addr 0x80000004, cpu_r_valid 3 cycles after accept.
REQ-038 SHALL cover: ready2 low 5 cycles in RSP -> cpu_r_valid/data stable, req_ready 0 throughout.
REQ-039 SHALL cover: flush in R state, axi_r_valid 2 cycles later -> beat consumed, cpu_r_valid never 1, req_ready 1 next cycle.
REQ-040 SHALL cover: axi_ar_ready held low 4 cycles -> axi_ar_valid/addr stable; axi_r_resp=2'b10 -> cpu_resp=2'b10.
REQ-041 SHALL cover: reset low during AR -> all outputs at reset values asynchronously; with ALIGN_CHECK_EN, req_pc=0x80000002 -> no ar_valid, cpu_resp=2'b10.
